// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - one-outstanding arbiter sharing an SRAM-like port between fetch and load/store
// Define ARB_RR_EN for round-robin on simultaneous requests; otherwise data has fixed priority.
module sram_like_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inst_req,
  input  logic [AW-1:0] inst_addr,
  input  logic          inst_cancel,
  output logic [DW-1:0] inst_rdata,
  output logic          inst_data_ok,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [1:0]    data_size,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  output logic [DW-1:0] data_rdata,
  output logic          data_data_ok,
  output logic          bus_req,
  output logic          bus_wr,
  output logic [1:0]    bus_size,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_wdata,
  input  logic          bus_addr_ok,
  input  logic          bus_data_ok,
  input  logic [DW-1:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} stateE;
  typedef enum logic {OWN_INST = 1'b0, OWN_DATA = 1'b1} ownerE;

  stateE         state, stateNext;
  ownerE         owner, ownerNext;
  logic          cancelled, cancelledNext;
  logic          busWrQ, busWrNext;
  logic [1:0]    busSizeQ, busSizeNext;
  logic [AW-1:0] busAddrQ, busAddrNext;
  logic [DW-1:0] busWdataQ, busWdataNext;

  logic grantAny;
  logic grantData;
  logic complete;

  assign grantAny = inst_req | data_req;

`ifdef ARB_RR_EN
  ownerE lastGrant;

  // On a collision the side that did not win last time goes first.
  assign grantData = data_req && (!inst_req || (lastGrant == OWN_INST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastGrant <= OWN_INST;
    end else if ((state == IDLE) && grantAny) begin
      lastGrant <= grantData ? OWN_DATA : OWN_INST;
    end
  end
`else
  assign grantData = data_req;
`endif

  // A completion is the downstream data_ok seen while a transaction is outstanding.
  assign complete = ((state == REQ) && bus_addr_ok && bus_data_ok) ||
                    ((state == RESP) && bus_data_ok);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= OWN_INST;
      cancelled <= 1'b0;
      busWrQ    <= 1'b0;
      busSizeQ  <= 2'b00;
      busAddrQ  <= '0;
      busWdataQ <= '0;
    end else begin
      state     <= stateNext;
      owner     <= ownerNext;
      cancelled <= cancelledNext;
      busWrQ    <= busWrNext;
      busSizeQ  <= busSizeNext;
      busAddrQ  <= busAddrNext;
      busWdataQ <= busWdataNext;
    end
  end

  always_comb begin
    stateNext     = state;
    ownerNext     = owner;
    cancelledNext = cancelled;
    busWrNext     = busWrQ;
    busSizeNext   = busSizeQ;
    busAddrNext   = busAddrQ;
    busWdataNext  = busWdataQ;

    case (state)
      IDLE: begin
        if (grantAny) begin
          stateNext = REQ;
          if (grantData) begin
            ownerNext    = OWN_DATA;
            busWrNext    = data_wr;
            busSizeNext  = data_size;
            busAddrNext  = data_addr;
            busWdataNext = data_wdata;
          end else begin
            ownerNext    = OWN_INST;
            busWrNext    = 1'b0;
            busSizeNext  = 2'd2;
            busAddrNext  = inst_addr;
            busWdataNext = '0;
          end
        end
      end
      REQ: begin
        if (bus_addr_ok) begin
          stateNext = bus_data_ok ? IDLE : RESP;
        end
      end
      RESP: begin
        if (bus_data_ok) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase

    // The flushed fetch still drains on the bus; only its response is dropped.
    if (complete) begin
      cancelledNext = 1'b0;
    end else if (inst_cancel && (owner == OWN_INST) && ((state == REQ) || (state == RESP))) begin
      cancelledNext = 1'b1;
    end
  end

  assign bus_req   = (state == REQ);
  assign bus_wr    = busWrQ;
  assign bus_size  = busSizeQ;
  assign bus_addr  = busAddrQ;
  assign bus_wdata = busWdataQ;

  // A flush landing in the completion cycle itself also hides that response.
  assign inst_data_ok = complete && (owner == OWN_INST) && !cancelled && !inst_cancel;
  assign data_data_ok = complete && (owner == OWN_DATA);
  assign inst_rdata   = bus_rdata;
  assign data_rdata   = bus_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - self-checking bench for sram_like_arbiter
`timescale 1ns/1ps
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_cancel, inst_data_ok;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  sram_like_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_rdata(inst_rdata), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic iReq; logic [31:0] iAddr; logic iCancel;
    logic dReq; logic dWr; logic [1:0] dSize; logic [31:0] dAddr; logic [31:0] dWdata;
    logic aOk; logic dOk; logic [31:0] rdata;
    logic eReq; logic eWr; logic [1:0] eSize; logic [31:0] eAddr; logic [31:0] eWdata;
    logic eIOk; logic eDOk; logic [31:0] eRdata;
  } vecT;

  function automatic vecT mk(
    input int iReq, input logic [31:0] iAddr, input int iCancel,
    input int dReq, input int dWr, input int dSize, input logic [31:0] dAddr, input logic [31:0] dWdata,
    input int aOk, input int dOk, input logic [31:0] rdata,
    input int eReq, input int eWr, input int eSize, input logic [31:0] eAddr, input logic [31:0] eWdata,
    input int eIOk, input int eDOk, input logic [31:0] eRdata);
    vecT v;
    v.iReq = (iReq != 0); v.iAddr = iAddr; v.iCancel = (iCancel != 0);
    v.dReq = (dReq != 0); v.dWr = (dWr != 0); v.dSize = 2'(dSize); v.dAddr = dAddr; v.dWdata = dWdata;
    v.aOk = (aOk != 0); v.dOk = (dOk != 0); v.rdata = rdata;
    v.eReq = (eReq != 0); v.eWr = (eWr != 0); v.eSize = 2'(eSize); v.eAddr = eAddr; v.eWdata = eWdata;
    v.eIOk = (eIOk != 0); v.eDOk = (eDOk != 0); v.eRdata = eRdata;
    return v;
  endfunction

  typedef struct {
    logic        isData;
    logic [31:0] addr;
    logic [31:0] rdata;
  } expT;

  expT         sbq[$];
  logic        pending;
  int          waitCnt;
  int          respDelay;
  int          done;
  logic [31:0] capAddr;

  function automatic logic [31:0] respData(input logic [31:0] a);
    return a ^ 32'h5A5A0000;
  endfunction

  task automatic clearInputs();
    inst_req = 1'b0; inst_addr = '0; inst_cancel = 1'b0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    clearInputs();
    pending = 1'b0;
    waitCnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic pushExp(input logic isData, input logic [31:0] addr);
    expT e;
    e.isData = isData;
    e.addr   = addr;
    e.rdata  = respData(addr);
    sbq.push_back(e);
  endtask

  // One cycle with a behavioural downstream: accept at once, respond after respDelay waits.
  task automatic stepAuto(input logic iReq, input logic [31:0] iAddr, input logic iCancel,
                          input logic dReq, input logic [31:0] dAddr);
    expT e;
    @(negedge clk);
    inst_req = iReq; inst_addr = iAddr; inst_cancel = iCancel;
    data_req = dReq; data_addr = dAddr; data_wr = 1'b0; data_size = 2'd2; data_wdata = '0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
    if (pending) begin
      if (waitCnt > 0) begin
        waitCnt--;
      end else begin
        bus_data_ok = 1'b1;
        bus_rdata   = respData(capAddr);
        pending     = 1'b0;
      end
    end else if (bus_req) begin
      bus_addr_ok = 1'b1;
      capAddr     = bus_addr;
      pending     = 1'b1;
      waitCnt     = respDelay;
      if (sbq.size() > 0) begin
        check("accept_addr", bus_addr, sbq[0].addr);
        check("accept_wr", 32'(bus_wr), 32'd0);
      end
    end
    #2;
    if ((sbq.size() > 0) && (inst_data_ok || data_data_ok)) begin
      e = sbq.pop_front();
      check("ok_owner", 32'(data_data_ok), 32'(e.isData));
      check("ok_exclusive", 32'(inst_data_ok & data_data_ok), 32'd0);
      check("ok_rdata", e.isData ? data_rdata : inst_rdata, e.rdata);
      done++;
    end else if (sbq.size() == 0) begin
      check("no_ok_inst", 32'(inst_data_ok), 32'd0);
      check("no_ok_data", 32'(data_data_ok), 32'd0);
    end
  endtask

  vecT vecs[18];

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk(1, 32'hBFC00000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 32'hBFC00000, 0, 0, 0, 0);
    vecs[2]  = mk(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 2, 32'hBFC00000, 0, 0, 0, 0);
    vecs[3]  = mk(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 32'hBFC00000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h24080001, 0, 0, 0, 0, 0, 1, 0, 32'h24080001);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 32'hBFC00004, 0, 1, 1, 2, 32'h80001000, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(1, 32'hBFC00004, 1, 1, 1, 2, 32'h80001000, 32'hDEADBEEF, 1, 0, 0, 1, 1, 2, 32'h80001000, 32'hDEADBEEF, 0, 0, 0);
    vecs[8]  = mk(1, 32'hBFC00004, 0, 1, 1, 2, 32'h80001000, 32'hDEADBEEF, 0, 1, 32'h11111111, 0, 0, 0, 0, 0, 0, 1, 32'h11111111);
    vecs[9]  = mk(1, 32'hBFC00004, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 32'hBFC00004, 0, 0, 0, 0, 0, 0, 1, 1, 32'h33334444, 1, 0, 2, 32'hBFC00004, 0, 1, 0, 32'h33334444);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h55555555, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 0, 0, 1, 0, 0, 32'h80000003, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, 0, 1, 0, 0, 32'h80000003, 0, 0, 0, 0, 1, 0, 0, 32'h80000003, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 1, 0, 0, 32'h80000003, 0, 1, 1, 32'h000000AB, 1, 0, 0, 32'h80000003, 0, 0, 1, 32'h000000AB);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    respDelay = 0;
    done      = 0;
    pending   = 1'b0;
    waitCnt   = 0;
    capAddr   = '0;

    // Reset state, with a stray downstream data_ok that must not leak through.
    rst = 1'b0;
    clearInputs();
    bus_data_ok = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_inst_ok", 32'(inst_data_ok), 32'd0);
    check("rst_data_ok", 32'(data_data_ok), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wr", 32'(bus_wr), 32'd0);
    check("rst_bus_size", 32'(bus_size), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus_data_ok = 1'b0;

    // Cycle-exact vectors: single fetch, collision, same-cycle completion, IDLE data_ok, byte load.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      inst_req = vecs[i].iReq; inst_addr = vecs[i].iAddr; inst_cancel = vecs[i].iCancel;
      data_req = vecs[i].dReq; data_wr = vecs[i].dWr; data_size = vecs[i].dSize;
      data_addr = vecs[i].dAddr; data_wdata = vecs[i].dWdata;
      bus_addr_ok = vecs[i].aOk; bus_data_ok = vecs[i].dOk; bus_rdata = vecs[i].rdata;
      #2;
      check($sformatf("v%0d_bus_req", i), 32'(bus_req), 32'(vecs[i].eReq));
      if (vecs[i].eReq) begin
        check($sformatf("v%0d_bus_addr", i), bus_addr, vecs[i].eAddr);
        check($sformatf("v%0d_bus_wr", i), 32'(bus_wr), 32'(vecs[i].eWr));
        check($sformatf("v%0d_bus_size", i), 32'(bus_size), 32'(vecs[i].eSize));
        if (vecs[i].eWr) check($sformatf("v%0d_bus_wdata", i), bus_wdata, vecs[i].eWdata);
      end
      check($sformatf("v%0d_inst_ok", i), 32'(inst_data_ok), 32'(vecs[i].eIOk));
      check($sformatf("v%0d_data_ok", i), 32'(data_data_ok), 32'(vecs[i].eDOk));
      if (vecs[i].eIOk) check($sformatf("v%0d_inst_rdata", i), inst_rdata, vecs[i].eRdata);
      if (vecs[i].eDOk) check($sformatf("v%0d_data_rdata", i), data_rdata, vecs[i].eRdata);
    end

    // Both sides held for four transactions.
    doReset();
    respDelay = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef ARB_RR_EN
      pushExp((k % 2) == 0, ((k % 2) == 0) ? 32'h00002000 : 32'h00001000);
`else
      pushExp(1'b1, 32'h00002000);
`endif
    end
    done = 0;
    for (int c = 0; c < 40 && done < 4; c++) stepAuto(1'b1, 32'h1000, 1'b0, 1'b1, 32'h2000);
    check("order_count", 32'(done), 32'd4);
    check("order_sb_empty", 32'(sbq.size()), 32'd0);
    sbq.delete();
    repeat (2) stepAuto(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Cancel during RESP: that response is swallowed, the next fetch is served.
    doReset();
    respDelay = 1;
    stepAuto(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    stepAuto(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    stepAuto(1'b1, 32'h3000, 1'b1, 1'b0, 32'h0);
    stepAuto(1'b1, 32'h3000, 1'b0, 1'b0, 32'h0);
    check("cancel_resp_drained", 32'(pending), 32'd0);
    pushExp(1'b0, 32'h00003004);
    for (int c = 0; c < 12 && sbq.size() > 0; c++) stepAuto(1'b1, 32'h3004, 1'b0, 1'b0, 32'h0);
    check("cancel_next_served", 32'(sbq.size()), 32'd0);
    sbq.delete();
    stepAuto(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    // Reset while waiting in RESP.
    doReset();
    respDelay = 3;
    stepAuto(1'b1, 32'h4000, 1'b0, 1'b0, 32'h0);
    stepAuto(1'b1, 32'h4000, 1'b0, 1'b0, 32'h0);
    stepAuto(1'b1, 32'h4000, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    bus_data_ok = 1'b1;
    bus_rdata = 32'h0BAD0BAD;
    #1;
    check("midrst_bus_req", 32'(bus_req), 32'd0);
    check("midrst_inst_ok", 32'(inst_data_ok), 32'd0);
    check("midrst_data_ok", 32'(data_data_ok), 32'd0);
    check("midrst_bus_addr", bus_addr, 32'd0);
    inst_req = 1'b0;
    pending = 1'b0;
    waitCnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus_data_ok = 1'b0;
    for (int c = 0; c < 4; c++) begin
      stepAuto(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check("postrst_bus_req", 32'(bus_req), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
